// File: rtl/solar_tracker_2axis.sv
// Two-axis sun-tracker controller.
// Each axis compares an opposing pair of light sensors and drives a pair of
// motor enables. Moves start and stop with hysteresis, every stop is followed
// by a settle period, and a run-time watchdog latches a fault.
// In exclusive mode only one axis may be moving at a time.

module solar_tracker_axis #(
   parameter int W          = 8,
   parameter int TH_START   = 10,
   parameter int TH_STOP    = 2,
   parameter int SETTLE_CYC = 16,
   parameter int MAX_RUN    = 1024,
   parameter int CNT_W      = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a,          // positive-side sample (N or E)
   input  logic [W-1:0] b,          // negative-side sample (S or W)
   input  logic         en,
   input  logic         allow,      // arbitration grant for IDLE -> MOVE
   input  logic         fault_clr,
   output logic         req,        // IDLE and an imbalance wants a move
   output logic         moving,     // registered state is MOVE_POS or MOVE_NEG
   output logic         busy_nxt,   // next state is MOVE or SETTLE
   output logic         mpos,
   output logic         mneg,
   output logic         flt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MOVE_POS = 3'd1,
      MOVE_NEG = 3'd2,
      SETTLE   = 3'd3,
      FAULT    = 3'd4
   } state_t;

   // Thresholds widened by one bit so that sample + threshold never wraps.
   localparam logic [W:0]       TH_START_X  = (W+1)'(TH_START);
   localparam logic [W:0]       TH_STOP_X   = (W+1)'(TH_STOP);
   localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(MAX_RUN - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [W:0]       a_x_s;
   logic [W:0]       b_x_s;
   logic             start_pos_s;
   logic             start_neg_s;
   logic             stop_pos_s;
   logic             stop_neg_s;

   // Imbalance decisions in W+1 bits.
   always_comb begin
      a_x_s       = {1'b0, a};
      b_x_s       = {1'b0, b};
      start_pos_s = en && (a_x_s > (b_x_s + TH_START_X));
      start_neg_s = en && (b_x_s > (a_x_s + TH_START_X));
      stop_pos_s  = !en || (a_x_s <= (b_x_s + TH_STOP_X));
      stop_neg_s  = !en || (b_x_s <= (a_x_s + TH_STOP_X));
   end

   // Next-state logic; stop has priority over the watchdog.
   always_comb begin
      state_nxt_s = state_r;
      req         = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_pos_s) begin
               req         = 1'b1;
               state_nxt_s = allow ? MOVE_POS : IDLE;
            end else if (start_neg_s) begin
               req         = 1'b1;
               state_nxt_s = allow ? MOVE_NEG : IDLE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MOVE_POS: begin
            if (stop_pos_s) begin
               state_nxt_s = SETTLE;
            end else if (cnt_r == RUN_LAST) begin
               state_nxt_s = FAULT;
            end else begin
               state_nxt_s = MOVE_POS;
            end
         end
         MOVE_NEG: begin
            if (stop_neg_s) begin
               state_nxt_s = SETTLE;
            end else if (cnt_r == RUN_LAST) begin
               state_nxt_s = FAULT;
            end else begin
               state_nxt_s = MOVE_NEG;
            end
         end
         SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SETTLE;
            end
         end
         FAULT: begin
            if (fault_clr) begin
               state_nxt_s = SETTLE;
            end else begin
               state_nxt_s = FAULT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Shared run/settle counter: restarts on every state change, counts in timed states.
   always_comb begin
      cnt_nxt_s = '0;
      if (state_nxt_s != state_r) begin
         cnt_nxt_s = '0;
      end else if ((state_r == MOVE_POS) || (state_r == MOVE_NEG) || (state_r == SETTLE)) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = '0;
      end
   end

   assign busy_nxt = (state_nxt_s == MOVE_POS) || (state_nxt_s == MOVE_NEG) ||
                     (state_nxt_s == SETTLE);
   assign moving   = mpos | mneg;

   // State, counter and registered Moore outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         mpos    <= 1'b0;
         mneg    <= 1'b0;
         flt     <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         mpos    <= (state_nxt_s == MOVE_POS);
         mneg    <= (state_nxt_s == MOVE_NEG);
         flt     <= (state_nxt_s == FAULT);
      end
   end

endmodule

module solar_tracker_2axis #(
   parameter int W          = 8,
   parameter int TH_START   = 10,
   parameter int TH_STOP    = 2,
   parameter int SETTLE_CYC = 16,
   parameter int MAX_RUN    = 1024,
   parameter int CNT_W      = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] lsn,
   input  logic [W-1:0] lse,
   input  logic [W-1:0] lss,
   input  logic [W-1:0] lsw,
   input  logic         en,
   input  logic         mode,
   input  logic         fault_clr,
   output logic         mn,
   output logic         ms,
   output logic         me,
   output logic         mw,
   output logic [1:0]   fault,
   output logic         busy
);

   logic ns_req_s;
   logic ns_moving_s;
   logic ns_busy_nxt_s;
   logic ns_allow_s;
   logic ns_flt_s;
   logic ew_req_s;
   logic ew_moving_s;
   logic ew_busy_nxt_s;
   logic ew_allow_s;
   logic ew_flt_s;

   // Exclusive arbitration: N/S wins a simultaneous request; E/W also waits
   // while N/S is moving or entering a move on this edge.
   assign ns_allow_s = mode | ~ew_moving_s;
   assign ew_allow_s = mode | ~(ns_moving_s | (ns_req_s & ns_allow_s));

   solar_tracker_axis #(
      .W(W), .TH_START(TH_START), .TH_STOP(TH_STOP),
      .SETTLE_CYC(SETTLE_CYC), .MAX_RUN(MAX_RUN), .CNT_W(CNT_W)
   ) u_ns (
      .clk(clk), .rst(rst), .a(lsn), .b(lss), .en(en),
      .allow(ns_allow_s), .fault_clr(fault_clr),
      .req(ns_req_s), .moving(ns_moving_s), .busy_nxt(ns_busy_nxt_s),
      .mpos(mn), .mneg(ms), .flt(ns_flt_s)
   );

   solar_tracker_axis #(
      .W(W), .TH_START(TH_START), .TH_STOP(TH_STOP),
      .SETTLE_CYC(SETTLE_CYC), .MAX_RUN(MAX_RUN), .CNT_W(CNT_W)
   ) u_ew (
      .clk(clk), .rst(rst), .a(lse), .b(lsw), .en(en),
      .allow(ew_allow_s), .fault_clr(fault_clr),
      .req(ew_req_s), .moving(ew_moving_s), .busy_nxt(ew_busy_nxt_s),
      .mpos(me), .mneg(mw), .flt(ew_flt_s)
   );

   assign fault = {ew_flt_s, ns_flt_s};

   // Registered busy flag from both axes' next states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
      end else begin
         busy <= ns_busy_nxt_s | ew_busy_nxt_s;
      end
   end

   // E/W request is only needed for arbitration toward N/S in a wider tree.
   logic unused_s;
   assign unused_s = ew_req_s;

endmodule

// File: tb/tb_solar_tracker_2axis.sv
// Directed bench for solar_tracker_2axis with SETTLE_CYC=4, MAX_RUN=20.
module tb_solar_tracker_2axis;

   logic       clk;
   logic       rst;
   logic [7:0] lsn, lse, lss, lsw;
   logic       en, mode, fault_clr;
   logic       mn, ms, me, mw;
   logic [1:0] fault;
   logic       busy;

   int tests_run;
   int tests_failed;

   solar_tracker_2axis #(
      .W(8), .TH_START(10), .TH_STOP(2), .SETTLE_CYC(4), .MAX_RUN(20), .CNT_W(5)
   ) dut (
      .clk(clk), .rst(rst), .lsn(lsn), .lse(lse), .lss(lss), .lsw(lsw),
      .en(en), .mode(mode), .fault_clr(fault_clr),
      .mn(mn), .ms(ms), .me(me), .mw(mw), .fault(fault), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then sit 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      step(2);
      tests_run++;
      if ({mn, ms, me, mw, fault, busy} !== 7'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs got=%b want=0000000", {mn, ms, me, mw, fault, busy});
      end
      #3 rst = 1'b0;
      step(2);
      tests_run++;
      if ({mn, ms, me, mw, fault, busy} !== 7'b0) begin
         tests_failed++;
         $display("FAIL idle_after_reset got=%b want=0000000", {mn, ms, me, mw, fault, busy});
      end
   endtask

   task automatic test_hysteresis();
      lsn = 8'd100; lss = 8'd80;
      step(1);
      tests_run++;
      if (mn !== 1'b1 || ms !== 1'b0) begin
         tests_failed++;
         $display("FAIL hyst_start mn=%b ms=%b want mn=1 ms=0", mn, ms);
      end
      lsn = 8'd83;   // imbalance 3 is above the stop threshold
      step(1);
      tests_run++;
      if (mn !== 1'b1) begin
         tests_failed++;
         $display("FAIL hyst_hold mn=%b want 1", mn);
      end
      lsn = 8'd82;   // imbalance 2 is at the stop threshold
      step(1);
      tests_run++;
      if (mn !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL hyst_stop mn=%b busy=%b want mn=0 busy=1", mn, busy);
      end
      for (int i = 0; i < 3; i++) begin
         step(1);
         tests_run++;
         if (busy !== 1'b1 || mn !== 1'b0) begin
            tests_failed++;
            $display("FAIL hyst_settle%0d busy=%b mn=%b want busy=1 mn=0", i, busy, mn);
         end
      end
      step(1);
      tests_run++;
      if (busy !== 1'b0 || mn !== 1'b0) begin
         tests_failed++;
         $display("FAIL hyst_idle busy=%b mn=%b want 0 0", busy, mn);
      end
      lsn = 8'd0; lss = 8'd0;
   endtask

   task automatic test_no_wrap();
      lsn = 8'd255; lss = 8'd250;
      step(2);
      tests_run++;
      if ({mn, ms, busy} !== 3'b000) begin
         tests_failed++;
         $display("FAIL nowrap_high got mn,ms,busy=%b want 000", {mn, ms, busy});
      end
      lsn = 8'd5; lss = 8'd255;
      step(1);
      tests_run++;
      if (ms !== 1'b1 || mn !== 1'b0) begin
         tests_failed++;
         $display("FAIL nowrap_neg ms=%b mn=%b want ms=1 mn=0", ms, mn);
      end
      lsn = 8'd250; lss = 8'd245;
      step(6);
      tests_run++;
      if ({mn, ms, busy} !== 3'b000) begin
         tests_failed++;
         $display("FAIL nowrap_diff5 got mn,ms,busy=%b want 000", {mn, ms, busy});
      end
      lsn = 8'd0; lss = 8'd0;
   endtask

   task automatic test_watchdog();
      int high;
      int guard;
      lsn = 8'd200; lss = 8'd0;
      step(1);
      high  = 0;
      guard = 0;
      while (mn === 1'b1 && guard < 40) begin
         high++;
         guard++;
         step(1);
      end
      tests_run++;
      if (high != 20) begin
         tests_failed++;
         $display("FAIL wdog_run_len got=%0d want=20", high);
      end
      step(3);
      tests_run++;
      if (fault !== 2'b01 || mn !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL wdog_fault fault=%b mn=%b busy=%b want 01 0 0", fault, mn, busy);
      end
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      tests_run++;
      if (fault !== 2'b00 || busy !== 1'b1 || mn !== 1'b0) begin
         tests_failed++;
         $display("FAIL wdog_clr fault=%b busy=%b mn=%b want 00 1 0", fault, busy, mn);
      end
      step(3);
      tests_run++;
      if (busy !== 1'b1 || mn !== 1'b0) begin
         tests_failed++;
         $display("FAIL wdog_settle busy=%b mn=%b want 1 0", busy, mn);
      end
      step(1);
      tests_run++;
      if (busy !== 1'b0 || mn !== 1'b0) begin
         tests_failed++;
         $display("FAIL wdog_idle busy=%b mn=%b want 0 0", busy, mn);
      end
      step(1);
      tests_run++;
      if (mn !== 1'b1) begin
         tests_failed++;
         $display("FAIL wdog_restart mn=%b want 1", mn);
      end
      lsn = 8'd0;
      step(7);
   endtask

   task automatic test_exclusive();
      mode = 1'b0;
      lsn = 8'd200; lss = 8'd0; lse = 8'd200; lsw = 8'd0;
      step(1);
      tests_run++;
      if (mn !== 1'b1 || me !== 1'b0) begin
         tests_failed++;
         $display("FAIL excl_start mn=%b me=%b want 1 0", mn, me);
      end
      step(1);
      tests_run++;
      if (mn !== 1'b1 || me !== 1'b0) begin
         tests_failed++;
         $display("FAIL excl_block mn=%b me=%b want 1 0", mn, me);
      end
      lss = 8'd200;
      step(1);
      tests_run++;
      if (mn !== 1'b0 || me !== 1'b0) begin
         tests_failed++;
         $display("FAIL excl_ns_stop mn=%b me=%b want 0 0", mn, me);
      end
      step(1);
      tests_run++;
      if (me !== 1'b1 || mn !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL excl_ew_start me=%b mn=%b busy=%b want 1 0 1", me, mn, busy);
      end
      lsw = 8'd200;
      step(8);
      tests_run++;
      if ({mn, ms, me, mw, fault, busy} !== 7'b0) begin
         tests_failed++;
         $display("FAIL excl_quiet got=%b want=0000000", {mn, ms, me, mw, fault, busy});
      end
   endtask

   task automatic test_concurrent();
      mode = 1'b1;
      lsn = 8'd200; lss = 8'd0; lse = 8'd200; lsw = 8'd0;
      step(1);
      tests_run++;
      if (mn !== 1'b1 || me !== 1'b1) begin
         tests_failed++;
         $display("FAIL conc_start mn=%b me=%b want 1 1", mn, me);
      end
      en = 1'b0;
      step(1);
      tests_run++;
      if (mn !== 1'b0 || me !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL conc_en_off mn=%b me=%b busy=%b want 0 0 1", mn, me, busy);
      end
      step(6);
      tests_run++;
      if ({mn, ms, me, mw, busy} !== 5'b0) begin
         tests_failed++;
         $display("FAIL conc_no_start_en0 got=%b want=00000", {mn, ms, me, mw, busy});
      end
      lsn = 8'd0; lse = 8'd0;
      en = 1'b1;
      mode = 1'b0;
      step(1);
   endtask

   task automatic test_async_reset();
      int guard;
      lsn = 8'd200; lss = 8'd0;
      step(1);
      tests_run++;
      if (mn !== 1'b1) begin
         tests_failed++;
         $display("FAIL arst_pre_move mn=%b want 1", mn);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (mn !== 1'b0 || busy !== 1'b0 || fault !== 2'b00) begin
         tests_failed++;
         $display("FAIL arst_move mn=%b busy=%b fault=%b want 0 0 00", mn, busy, fault);
      end
      rst = 1'b0;
      step(1);
      tests_run++;
      if (mn !== 1'b1) begin
         tests_failed++;
         $display("FAIL arst_restart mn=%b want 1", mn);
      end
      guard = 0;
      while (fault !== 2'b01 && guard < 40) begin
         guard++;
         step(1);
      end
      tests_run++;
      if (fault !== 2'b01) begin
         tests_failed++;
         $display("FAIL arst_reach_fault fault=%b want 01", fault);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (fault !== 2'b00 || mn !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL arst_fault fault=%b mn=%b busy=%b want 00 0 0", fault, mn, busy);
      end
      lsn = 8'd0;
      rst = 1'b0;
      step(2);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b1;
      lsn       = 8'd0;
      lse       = 8'd0;
      lss       = 8'd0;
      lsw       = 8'd0;
      en        = 1'b1;
      mode      = 1'b0;
      fault_clr = 1'b0;
      test_reset();
      test_hysteresis();
      test_no_wrap();
      test_watchdog();
      test_exclusive();
      test_concurrent();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
